// File: rtl/cim_cmd_scheduler.sv
// In-order command FIFO and issuer in front of the CIM macro controller.
// Optional perf counters are compiled in with `define CIM_SCHED_PERF_EN.
module cim_cmd_scheduler #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             rd_valid,
  output logic [15:0]      rd_data,
  output logic             busy,
  output logic             Compute_valid,
  input  logic             Compute_ready,
  output logic [24:0]      Compute_command,
  output logic             ExLdSt_valid,
  output logic [6:0]       ExLdSt_command,
  output logic [15:0]      ExLdSt_wr_data,
`ifdef CIM_SCHED_PERF_EN
  input  logic [15:0]      ExLdSt_rd_data,
  output logic [31:0]      perf_cmp_cycles,
  output logic [31:0]      perf_cmd_count
`else
  input  logic [15:0]      ExLdSt_rd_data
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    LDST
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             done;
  logic             is_rd;
  logic [CMD_W-1:0] head;
  logic [24:0]      issue_q;
  logic             unused_head;

  // Extra pointer bit separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign cmd_ready = ~full;
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign busy      = (state_q != IDLE) | ~empty;

  // Reserved command bits carry no meaning for the macro.
  assign unused_head = ^head[CMD_W-2:25];

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= cmd_data;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Issue state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: completion pops the next entry with no bubble.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = head[CMD_W-1] ? LDST : CMP;
        end
      end
      CMP:     done = Compute_ready;
      LDST:    done = 1'b1;
      default: state_d = IDLE;
    endcase
    if (done) begin
      if (!empty) begin
        pop     = 1'b1;
        state_d = head[CMD_W-1] ? LDST : CMP;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Issue register loaded from the FIFO head on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      issue_q <= '0;
    else if (pop) issue_q <= head[24:0];
  end

  // Macro-facing outputs are zero outside the matching state.
  always_comb begin
    Compute_valid   = (state_q == CMP);
    ExLdSt_valid    = (state_q == LDST);
    Compute_command = '0;
    ExLdSt_command  = '0;
    ExLdSt_wr_data  = '0;
    if (Compute_valid) Compute_command = issue_q;
    if (ExLdSt_valid) begin
      ExLdSt_command = issue_q[6:0];
      ExLdSt_wr_data = issue_q[22:7];
    end
  end

  assign is_rd = (state_q == LDST) & ~issue_q[6];

  // Read data capture; rd_data holds until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= is_rd;
      if (is_rd) rd_data <= ExLdSt_rd_data;
    end
  end

`ifdef CIM_SCHED_PERF_EN
  // Saturating perf counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cmp_cycles <= '0;
      perf_cmd_count  <= '0;
    end else begin
      if (state_q == CMP && perf_cmp_cycles != '1)
        perf_cmp_cycles <= perf_cmp_cycles + 32'd1;
      if (done && perf_cmd_count != '1)
        perf_cmd_count <= perf_cmd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cim_cmd_scheduler.sv
// Self-checking bench for cim_cmd_scheduler.
// Scoreboard queues hold expected issued commands and read data.
module tb_cim_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        busy;
  logic        Compute_valid;
  logic        Compute_ready;
  logic [24:0] Compute_command;
  logic        ExLdSt_valid;
  logic [6:0]  ExLdSt_command;
  logic [15:0] ExLdSt_wr_data;
  logic [15:0] ExLdSt_rd_data;
`ifdef CIM_SCHED_PERF_EN
  logic [31:0] perf_cmp_cycles;
  logic [31:0] perf_cmd_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [15:0] rd_q [$];
  logic [31:0] mon_c;
  logic [15:0] mon_d;

  always #5 clk = ~clk;

  cim_cmd_scheduler #(.DEPTH(4), .CMD_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_data        (cmd_data),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .busy            (busy),
    .Compute_valid   (Compute_valid),
    .Compute_ready   (Compute_ready),
    .Compute_command (Compute_command),
    .ExLdSt_valid    (ExLdSt_valid),
    .ExLdSt_command  (ExLdSt_command),
    .ExLdSt_wr_data  (ExLdSt_wr_data),
`ifdef CIM_SCHED_PERF_EN
    .ExLdSt_rd_data  (ExLdSt_rd_data),
    .perf_cmp_cycles (perf_cmp_cycles),
    .perf_cmd_count  (perf_cmd_count)
`else
    .ExLdSt_rd_data  (ExLdSt_rd_data)
`endif
  );

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (Compute_valid && Compute_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_cmp unexpected got=%h want=none",
                   Compute_command);
        end else begin
          mon_c = exp_q.pop_front();
          if (mon_c[31] !== 1'b0 ||
              Compute_command !== mon_c[24:0]) begin
            errors++;
            $display("FAIL sb_cmp got=%h want=%h",
                     Compute_command, mon_c);
          end
        end
      end
      if (ExLdSt_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_ldst unexpected got=%h want=none",
                   ExLdSt_command);
        end else begin
          mon_c = exp_q.pop_front();
          if (mon_c[31] !== 1'b1 ||
              {ExLdSt_command, ExLdSt_wr_data} !==
              {mon_c[6:0], mon_c[22:7]}) begin
            errors++;
            $display("FAIL sb_ldst got=%h/%h want=%h",
                     ExLdSt_command, ExLdSt_wr_data, mon_c);
          end
        end
      end
      if (rd_valid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL sb_rd unexpected got=%h want=none",
                   rd_data);
        end else begin
          mon_d = rd_q.pop_front();
          if (rd_data !== mon_d) begin
            errors++;
            $display("FAIL sb_rd got=%h want=%h", rd_data, mon_d);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    rd_q.delete();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // Offer one command; records expectations when accepted.
  task automatic send(input logic [31:0] c);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = c;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (cmd_ready) begin
        exp_q.push_back(c);
        if (c[31] && !c[6]) rd_q.push_back(ExLdSt_rd_data);
        ok = 1'b1;
      end
      cyc();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout got=0 want=1");
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    cmd_valid      = 1'b0;
    cmd_data       = '0;
    Compute_ready  = 1'b0;
    ExLdSt_rd_data = '0;
    cyc();
    cyc();
    chk("rst_cvalid", {31'd0, Compute_valid}, 32'd0);
    chk("rst_lvalid", {31'd0, ExLdSt_valid}, 32'd0);
    chk("rst_rvalid", {31'd0, rd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ccmd", {7'd0, Compute_command}, 32'd0);
    chk("rst_rdata", {16'd0, rd_data}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy2", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_add();
    Compute_ready = 1'b1;
    cmd_valid     = 1'b1;
    cmd_data      = 32'h00A420C4;
    exp_q.push_back(32'h00A420C4);
    cyc();
    cmd_valid = 1'b0;
    chk("add_c1_valid", {31'd0, Compute_valid}, 32'd0);
    cyc();
    chk("add_c2_valid", {31'd0, Compute_valid}, 32'd1);
    chk("add_c2_cmd", {7'd0, Compute_command}, 32'h00A420C4);
    cyc();
    chk("add_c3_valid", {31'd0, Compute_valid}, 32'd0);
    chk("add_c3_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_mul_write();
    logic [31:0] wr;
    wr = {1'b1, 8'd0, 16'hBEEF, 7'h4A};
    do_reset();
    Compute_ready = 1'b0;
    cmd_valid     = 1'b1;
    cmd_data      = 32'h00E81005;
    exp_q.push_back(32'h00E81005);
    cyc();
    cmd_data = wr;
    exp_q.push_back(wr);
    cyc();
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) Compute_ready = 1'b1;
      chk("mul_hold_valid", {31'd0, Compute_valid}, 32'd1);
      chk("mul_hold_cmd", {7'd0, Compute_command}, 32'h00E81005);
      cyc();
    end
    Compute_ready = 1'b0;
    chk("wr_cvalid", {31'd0, Compute_valid}, 32'd0);
    chk("wr_lvalid", {31'd0, ExLdSt_valid}, 32'd1);
    chk("wr_data", {16'd0, ExLdSt_wr_data}, 32'h0000BEEF);
    chk("wr_cmd", {25'd0, ExLdSt_command}, 32'h4A);
    cyc();
    chk("wr_pulse_end", {31'd0, ExLdSt_valid}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd0);
    chk("wr_no_rd", {31'd0, rd_valid}, 32'd0);
`ifdef CIM_SCHED_PERF_EN
    chk("perf_cycles", perf_cmp_cycles, 32'd4);
    chk("perf_count", perf_cmd_count, 32'd2);
`endif
  endtask

  task automatic test_read();
    ExLdSt_rd_data = 16'h1234;
    cmd_valid      = 1'b1;
    cmd_data       = 32'h80000003;
    exp_q.push_back(32'h80000003);
    rd_q.push_back(16'h1234);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    chk("rd_lvalid", {31'd0, ExLdSt_valid}, 32'd1);
    chk("rd_cmd", {25'd0, ExLdSt_command}, 32'h03);
    chk("rd_early", {31'd0, rd_valid}, 32'd0);
    cyc();
    ExLdSt_rd_data = 16'h5555;
    chk("rd_lvalid_end", {31'd0, ExLdSt_valid}, 32'd0);
    chk("rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("rd_data", {16'd0, rd_data}, 32'h1234);
    cyc();
    chk("rd_valid_end", {31'd0, rd_valid}, 32'd0);
    chk("rd_hold", {16'd0, rd_data}, 32'h1234);
  endtask

  task automatic test_back_to_back();
    logic [31:0] cmds [5];
    int n;
    int act;
    cmds[0] = 32'h00000111;
    cmds[1] = {1'b1, 8'd0, 16'h1111, 7'h45};
    cmds[2] = 32'h80000005;
    cmds[3] = 32'h00012345;
    cmds[4] = {1'b1, 8'd0, 16'hCAFE, 7'h7F};
    Compute_ready  = 1'b0;
    ExLdSt_rd_data = 16'hA5A5;
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", {31'd0, cmd_ready}, 32'd1);
      send(cmds[i]);
    end
    cmd_valid = 1'b0;
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("full_cmd", {7'd0, Compute_command}, 32'h111);
    Compute_ready = 1'b1;
    n   = 0;
    act = 0;
    while (busy && n < 50) begin
      if (Compute_valid || ExLdSt_valid) act++;
      cyc();
      n++;
    end
    Compute_ready = 1'b0;
    chk("drain_cycles", n, 32'd5);
    chk("drain_active", act, 32'd5);
    cyc();
    chk("drain_ready", {31'd0, cmd_ready}, 32'd1);
    chk("drain_sb", exp_q.size() + rd_q.size(), 32'd0);
  endtask

  task automatic test_reset_mid();
    Compute_ready = 1'b0;
    cmd_valid     = 1'b1;
    cmd_data      = 32'h00E81005;
    exp_q.push_back(32'h00E81005);
    cyc();
    cmd_data = 32'h00000777;
    exp_q.push_back(32'h00000777);
    cyc();
    cmd_valid = 1'b0;
    chk("mid_valid", {31'd0, Compute_valid}, 32'd1);
    chk("mid_cmd", {7'd0, Compute_command}, 32'h00E81005);
    rst = 1'b1;
    exp_q.delete();
    rd_q.delete();
    #1;
    chk("mid_rst_valid", {31'd0, Compute_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_cmd", {7'd0, Compute_command}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("mid_post_busy", {31'd0, busy}, 32'd0);
    chk("mid_post_valid", {31'd0, Compute_valid}, 32'd0);
    cyc();
    chk("mid_post_valid2", {31'd0, Compute_valid}, 32'd0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
